// File: rtl/seg_scan_ctrl.sv
// Time-multiplexed scan controller for an NDIG-digit common-anode 7-segment display.
// Optional decimal-point support is enabled by defining SEG_SCAN_DP_EN.
module seg_scan_ctrl #(
  parameter int NDIG = 8,
  parameter int DIV  = 1000,
  parameter int DEAD = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [$clog2(NDIG)-1:0]  wr_idx,
  input  logic [3:0]               wr_data,
  input  logic                     wr_blank,
`ifdef SEG_SCAN_DP_EN
  input  logic                     wr_dp,
  output logic                     dp,
`endif
  output logic [NDIG-1:0]          an,
  output logic [6:0]               seg,
  output logic [$clog2(NDIG)-1:0]  scan_idx
);

  localparam int IW   = $clog2(NDIG);
  localparam int CMAX = (DIV > DEAD) ? DIV : DEAD;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] DEAD_LAST = CW'(DEAD - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NDIG - 1);
  localparam logic [IW:0]   NDIG_W    = (IW + 1)'(NDIG);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_t;

  // Active-low {g,f,e,d,c,b,a} code for one hex digit.
  function automatic logic [6:0] seg_code(input logic [3:0] val, input logic blank);
    logic [6:0] code;
    case (val)
      4'h0: code = 7'h40;
      4'h1: code = 7'h79;
      4'h2: code = 7'h24;
      4'h3: code = 7'h30;
      4'h4: code = 7'h19;
      4'h5: code = 7'h12;
      4'h6: code = 7'h02;
      4'h7: code = 7'h78;
      4'h8: code = 7'h00;
      4'h9: code = 7'h10;
      4'hA: code = 7'h08;
      4'hB: code = 7'h03;
      4'hC: code = 7'h46;
      4'hD: code = 7'h21;
      4'hE: code = 7'h06;
      4'hF: code = 7'h0E;
      default: code = 7'h7F;
    endcase
    return blank ? 7'h7F : code;
  endfunction

  state_t          state_r, state_nxt_s;
  logic [CW-1:0]   cnt_r, cnt_nxt_s;
  logic [IW-1:0]   scan_idx_r, idx_nxt_s;
  logic [NDIG-1:0] an_r, an_nxt_s, sel_s;
  logic [6:0]      seg_r, seg_nxt_s;
  logic            wr_ready_r;
  logic [3:0]      data_r [NDIG];
  logic [NDIG-1:0] blank_r;
  logic            wr_fire_s, wr_ok_s, wr_hit_s;
  logic [3:0]      fetch_data_s;
  logic            fetch_blank_s;
`ifdef SEG_SCAN_DP_EN
  logic [NDIG-1:0] dp_mem_r;
  logic            dp_r, dp_nxt_s, fetch_dp_s;
`endif

  assign wr_ready = wr_ready_r;
  assign an       = an_r;
  assign seg      = seg_r;
  assign scan_idx = scan_idx_r;
`ifdef SEG_SCAN_DP_EN
  assign dp       = dp_r;
`endif

  // Write decode and write-through fetch of the digit owning the next slot.
  always_comb begin
    wr_fire_s     = wr_valid && wr_ready_r;
    wr_ok_s       = wr_fire_s && ({1'b0, wr_idx} < NDIG_W);
    wr_hit_s      = wr_ok_s && (wr_idx == scan_idx_r);
    fetch_data_s  = wr_hit_s ? wr_data  : data_r[scan_idx_r];
    fetch_blank_s = wr_hit_s ? wr_blank : blank_r[scan_idx_r];
`ifdef SEG_SCAN_DP_EN
    fetch_dp_s    = wr_hit_s ? wr_dp    : dp_mem_r[scan_idx_r];
`endif
    sel_s             = '1;
    sel_s[scan_idx_r] = 1'b0;
  end

  // Next-state, slot counter and next registered output values.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    idx_nxt_s   = scan_idx_r;
    an_nxt_s    = '1;
    seg_nxt_s   = 7'h7F;
`ifdef SEG_SCAN_DP_EN
    dp_nxt_s    = 1'b1;
`endif
    if (!en) begin
      state_nxt_s = IDLE;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        IDLE: begin
          state_nxt_s = BLANK;
          cnt_nxt_s   = '0;
        end
        BLANK: begin
          if (cnt_r == DEAD_LAST) begin
            state_nxt_s = SHOW;
            cnt_nxt_s   = '0;
            an_nxt_s    = sel_s;
            seg_nxt_s   = seg_code(fetch_data_s, fetch_blank_s);
`ifdef SEG_SCAN_DP_EN
            dp_nxt_s    = ~fetch_dp_s;
`endif
          end else begin
            cnt_nxt_s = cnt_r + CW'(1);
          end
        end
        SHOW: begin
          if (cnt_r == DIV_LAST) begin
            state_nxt_s = BLANK;
            cnt_nxt_s   = '0;
            idx_nxt_s   = (scan_idx_r == IDX_LAST) ? IW'(0) : scan_idx_r + IW'(1);
          end else begin
            // Hold the fetched code for the whole slot so mid-slot writes never glitch.
            cnt_nxt_s = cnt_r + CW'(1);
            an_nxt_s  = an_r;
            seg_nxt_s = seg_r;
`ifdef SEG_SCAN_DP_EN
            dp_nxt_s  = dp_r;
`endif
          end
        end
        default: begin
          state_nxt_s = IDLE;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // State, counter and registered pin outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      cnt_r      <= '0;
      scan_idx_r <= '0;
      an_r       <= '1;
      seg_r      <= 7'h7F;
      wr_ready_r <= 1'b0;
`ifdef SEG_SCAN_DP_EN
      dp_r       <= 1'b1;
`endif
    end else begin
      state_r    <= state_nxt_s;
      cnt_r      <= cnt_nxt_s;
      scan_idx_r <= idx_nxt_s;
      an_r       <= an_nxt_s;
      seg_r      <= seg_nxt_s;
      wr_ready_r <= 1'b1;
`ifdef SEG_SCAN_DP_EN
      dp_r       <= dp_nxt_s;
`endif
    end
  end

  // Per-digit storage; out-of-range writes complete the handshake but are dropped.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NDIG; i++) begin
        data_r[i] <= 4'h0;
      end
      blank_r <= '1;
`ifdef SEG_SCAN_DP_EN
      dp_mem_r <= '0;
`endif
    end else if (wr_ok_s) begin
      data_r[wr_idx]  <= wr_data;
      blank_r[wr_idx] <= wr_blank;
`ifdef SEG_SCAN_DP_EN
      dp_mem_r[wr_idx] <= wr_dp;
`endif
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl (NDIG=4, DIV=3, DEAD=1) using an expected-slot queue.
module tb_seg_scan_ctrl;

  localparam int NDIG = 4;
  localparam int DIV  = 3;
  localparam int DEAD = 1;

  logic       clk = 1'b0;
  logic       rst, en, wr_valid, wr_blank;
  logic       wr_ready;
  logic [1:0] wr_idx;
  logic [3:0] wr_data;
  logic [3:0] an;
  logic [6:0] seg;
  logic [1:0] scan_idx;
`ifdef SEG_SCAN_DP_EN
  logic       wr_dp = 1'b0;
  logic       dp;
`endif

  seg_scan_ctrl #(.NDIG(NDIG), .DIV(DIV), .DEAD(DEAD)) dut (
    .clk(clk), .rst(rst), .en(en),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_idx(wr_idx),
    .wr_data(wr_data), .wr_blank(wr_blank),
`ifdef SEG_SCAN_DP_EN
    .wr_dp(wr_dp), .dp(dp),
`endif
    .an(an), .seg(seg), .scan_idx(scan_idx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0] idx;
    logic [6:0] seg;
  } exp_t;

  exp_t       exp_q[$];
  int         checks = 0;
  int         errors = 0;
  int         slot_cyc = 0;
  logic [6:0] seg_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [3:0] model_val [NDIG];
  logic       model_blank [NDIG];

  task automatic model_reset();
    for (int i = 0; i < NDIG; i++) begin
      model_val[i]   = 4'h0;
      model_blank[i] = 1'b1;
    end
  endtask

  task automatic push_exp(input int i);
    exp_t e;
    e.idx = 2'(i);
    e.seg = model_blank[i] ? 7'h7F : seg_tab[model_val[i]];
    exp_q.push_back(e);
  endtask

  // Wait (bounded) for an anode to go low after an all-dark sample.
  task automatic wait_lit();
    logic [3:0] prev;
    bit ok;
    prev = an;
    ok = 1'b0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (prev == 4'hF && an != 4'hF) begin
        ok = 1'b1;
        break;
      end
      prev = an;
    end
    slot_cyc = cyc;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL slot_timeout: an=%b after 40 cycles, expected a lit anode", an);
    end
  endtask

  task automatic do_write(input logic [1:0] idx, input logic [3:0] data, input logic blank);
    wr_valid = 1'b1;
    wr_idx   = idx;
    wr_data  = data;
    wr_blank = blank;
    @(negedge clk);
    wr_valid = 1'b0;
    model_val[idx]   = data;
    model_blank[idx] = blank;
  endtask

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; wr_valid = 1'b0; wr_idx = 2'd0; wr_data = 4'h0; wr_blank = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || scan_idx !== 2'd0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_vals: an=%b seg=%h idx=%0d rdy=%b, expected 1111/7f/0/0", an, seg, scan_idx, wr_ready);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1 || an !== 4'hF) begin
      errors++;
      $display("FAIL ready_after_reset: rdy=%b an=%b, expected 1/1111", wr_ready, an);
    end
  endtask

  task automatic test_scan();
    exp_t e;
    int cyc0, last;
    en = 1'b1;
    cyc0 = cyc;
    last = 0;
    @(negedge clk);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F) begin
      errors++;
      $display("FAIL blank_gap: an=%b seg=%h, expected 1111/7f", an, seg);
    end
    for (int k = 0; k < 5; k++) push_exp(k % NDIG);
    for (int k = 0; k < 5; k++) begin
      wait_lit();
      checks++;
      if (k == 0 && slot_cyc - cyc0 != 1 + DEAD) begin
        errors++;
        $display("FAIL first_lit_latency: %0d cycles, expected %0d", slot_cyc - cyc0, 1 + DEAD);
      end else if (k != 0 && slot_cyc - last != DIV + DEAD) begin
        errors++;
        $display("FAIL slot_period: %0d cycles, expected %0d", slot_cyc - last, DIV + DEAD);
      end
      last = slot_cyc;
      e = exp_q.pop_front();
      checks++;
      if (an !== ~(4'b0001 << e.idx) || seg !== e.seg || scan_idx !== e.idx) begin
        errors++;
        $display("FAIL scan_slot: an=%b seg=%h idx=%0d, expected an=%b seg=%h idx=%0d",
                 an, seg, scan_idx, ~(4'b0001 << e.idx), e.seg, e.idx);
      end
    end
  endtask

  task automatic test_writes();
    exp_t e;
    do_write(2'd0, 4'h3, 1'b0);
    do_write(2'd1, 4'hA, 1'b0);
    do_write(2'd2, 4'hF, 1'b0);
    push_exp(1); push_exp(2); push_exp(3); push_exp(0);
    for (int k = 0; k < 4; k++) begin
      wait_lit();
      e = exp_q.pop_front();
      checks++;
      if (an !== ~(4'b0001 << e.idx) || seg !== e.seg || scan_idx !== e.idx) begin
        errors++;
        $display("FAIL write_slot: an=%b seg=%h idx=%0d, expected an=%b seg=%h idx=%0d",
                 an, seg, scan_idx, ~(4'b0001 << e.idx), e.seg, e.idx);
      end
    end
  endtask

  task automatic test_write_through();
    exp_t e;
    repeat (3) @(negedge clk);
    // This write lands on the same edge that fetches digit 1.
    wr_valid = 1'b1; wr_idx = 2'd1; wr_data = 4'h5; wr_blank = 1'b0;
    model_val[1] = 4'h5; model_blank[1] = 1'b0;
    push_exp(1);
    wait_lit();
    e = exp_q.pop_front();
    checks++;
    if (an !== 4'b1101 || seg !== e.seg || seg !== 7'h12 || scan_idx !== 2'd1) begin
      errors++;
      $display("FAIL write_through: an=%b seg=%h idx=%0d, expected an=1101 seg=12 idx=1", an, seg, scan_idx);
    end
    wr_data = 4'h0;
    @(negedge clk);
    wr_valid = 1'b0;
    model_val[1] = 4'h0;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if (an !== 4'b1101 || seg !== 7'h12) begin
        errors++;
        $display("FAIL mid_slot_write: an=%b seg=%h, expected an=1101 seg=12", an, seg);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_enable_drop();
    exp_t e;
    int cyc0;
    push_exp(2);
    wait_lit();
    e = exp_q.pop_front();
    checks++;
    if (an !== 4'b1011 || seg !== e.seg || scan_idx !== 2'd2) begin
      errors++;
      $display("FAIL pre_drop_slot: an=%b seg=%h idx=%0d, expected an=1011 seg=%h idx=2", an, seg, scan_idx, e.seg);
    end
    en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (an !== 4'hF || seg !== 7'h7F || scan_idx !== 2'd2) begin
        errors++;
        $display("FAIL en_drop: an=%b seg=%h idx=%0d, expected 1111/7f/2", an, seg, scan_idx);
      end
    end
    en = 1'b1;
    cyc0 = cyc;
    push_exp(2);
    push_exp(3);
    wait_lit();
    checks++;
    if (slot_cyc - cyc0 != 1 + DEAD) begin
      errors++;
      $display("FAIL resume_latency: %0d cycles, expected %0d", slot_cyc - cyc0, 1 + DEAD);
    end
    for (int k = 0; k < 2; k++) begin
      if (k != 0) wait_lit();
      e = exp_q.pop_front();
      checks++;
      if (an !== ~(4'b0001 << e.idx) || seg !== e.seg || scan_idx !== e.idx) begin
        errors++;
        $display("FAIL resume_slot: an=%b seg=%h idx=%0d, expected an=%b seg=%h idx=%0d",
                 an, seg, scan_idx, ~(4'b0001 << e.idx), e.seg, e.idx);
      end
    end
  endtask

  task automatic test_reset_mid_slot();
    exp_t e;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (an !== 4'hF || seg !== 7'h7F || scan_idx !== 2'd0 || wr_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: an=%b seg=%h idx=%0d rdy=%b, expected 1111/7f/0/0", an, seg, scan_idx, wr_ready);
    end
    rst = 1'b0;
    model_reset();
    @(negedge clk);
    checks++;
    if (wr_ready !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_mid_reset: rdy=%b, expected 1", wr_ready);
    end
    for (int k = 0; k < NDIG; k++) push_exp(k);
    for (int k = 0; k < NDIG; k++) begin
      wait_lit();
      e = exp_q.pop_front();
      checks++;
      if (an !== ~(4'b0001 << e.idx) || seg !== e.seg || scan_idx !== e.idx) begin
        errors++;
        $display("FAIL post_reset_slot: an=%b seg=%h idx=%0d, expected an=%b seg=%h idx=%0d",
                 an, seg, scan_idx, ~(4'b0001 << e.idx), e.seg, e.idx);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan();
    test_writes();
    test_write_through();
    test_enable_drop();
    test_reset_mid_slot();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
